// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: 8-phase instruction sequencer with run/halt/step control and retired-instruction count
module cpu_seq_ctrl #(
  parameter bit AUTO_RUN = 1'b0,
  parameter int ICNT_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [2:0]        opcode,
  input  logic              zero,
  input  logic              run_req,
  input  logic              step_en,
  input  logic              step_req,
  output logic              sel,
  output logic              rd,
  output logic              ld_ir,
  output logic              inc_pc,
  output logic              ld_pc,
  output logic              data_e,
  output logic              ld_ac,
  output logic              wr,
  output logic              halt,
  output logic [2:0]        phase,
  output logic [1:0]        run_st,
  output logic              instr_done,
  output logic [ICNT_W-1:0] icnt
);
  typedef enum logic [1:0] {STOPPED = 2'd0, RUNNING = 2'd1, HALTED = 2'd2, PAUSED = 2'd3} st_t;
  localparam st_t RST_ST = AUTO_RUN ? RUNNING : STOPPED;
  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, STO = 3'd6, JMP = 3'd7;
  st_t st, st_n;
  logic [2:0] ph_n;
  logic done_n, alu, jmp, sto;
  assign run_st = st;
  assign alu = opcode >= 3'd2 && opcode <= 3'd5;
  assign jmp = opcode == JMP;
  assign sto = opcode == STO;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st         <= RST_ST;
      phase      <= 3'd0;
      instr_done <= 1'b0;
      icnt       <= '0;
    end else begin
      st         <= st_n;
      phase      <= ph_n;
      instr_done <= done_n;
      icnt       <= icnt + ICNT_W'(done_n);
    end
  always_comb begin
    st_n   = st;
    ph_n   = phase;
    done_n = 1'b0;
    case (st)
      STOPPED: st_n = run_req ? RUNNING : STOPPED;
      RUNNING:
        if (phase == 3'd4 && opcode == HLT) st_n = HALTED;
        else begin
          ph_n   = phase + 3'd1;
          done_n = phase == 3'd7;
          st_n   = (phase == 3'd7 && step_en) ? PAUSED : RUNNING;
        end
      // resuming at phase 5 lets HLT finish without a second phase-4 inc_pc
      HALTED:
        if (run_req) begin
          st_n = RUNNING;
          ph_n = 3'd5;
        end
      PAUSED:
        if (step_req || run_req) begin
          st_n = RUNNING;
          ph_n = 3'd0;
        end
    endcase
  end
  always_comb begin
    {sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt} = '0;
    if (st == HALTED) halt = 1'b1;
    else if (st == RUNNING)
      case (phase)
        3'd0: sel = 1'b1;
        3'd1: {sel, rd} = 2'b11;
        3'd2, 3'd3: {sel, rd, ld_ir} = 3'b111;
        3'd4: begin
          inc_pc = 1'b1;
          halt   = opcode == HLT;
        end
        3'd5: rd = alu;
        3'd6: begin
          rd     = alu;
          inc_pc = opcode == SKZ && zero;
          ld_pc  = jmp;
          data_e = sto;
        end
        default: begin
          rd     = alu;
          inc_pc = jmp;
          ld_pc  = jmp;
          ld_ac  = alu;
          wr     = sto;
          data_e = sto;
        end
      endcase
  end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed table, corner sequences and random stimulus against a rule-based model
module tb_cpu_seq_ctrl;
  logic clk = 1'b0;
  logic rstn, zero, run_req, step_en, step_req;
  logic [2:0] opcode;
  logic sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, instr_done;
  logic [2:0] phase;
  logic [1:0] run_st;
  logic [1:0] icnt;
  logic [8:0] strb, obs;
  int checks = 0, errors = 0;
  int ms, mp, mi;
  bit md;

  cpu_seq_ctrl #(.AUTO_RUN(1'b0), .ICNT_W(2)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .zero(zero), .run_req(run_req),
    .step_en(step_en), .step_req(step_req), .sel(sel), .rd(rd), .ld_ir(ld_ir),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr),
    .halt(halt), .phase(phase), .run_st(run_st), .instr_done(instr_done), .icnt(icnt)
  );

  always #5 clk = ~clk;
  assign strb = {sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt};

  typedef struct {
    logic       rr;
    logic [2:0] ph;
    logic [1:0] st;
    logic [8:0] s;
  } vec_t;
  vec_t tbl[9];

  // Each strobe described by the rule that enables it, not by phase decode.
  function automatic logic [8:0] exp_strb(int s, int p, int op, bit z);
    bit alu;
    alu = op >= 2 && op <= 5;
    if (s == 2) return 9'b1;
    if (s != 1) return 9'b0;
    return {p < 4, (p >= 1 && p <= 3) || (p >= 5 && alu), p == 2 || p == 3,
            p == 4 || (p == 6 && op == 1 && z) || (p == 7 && op == 7),
            op == 7 && p >= 6, op == 6 && p >= 6, p == 7 && alu, p == 7 && op == 6,
            p == 4 && op == 0};
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; mp = 0; mi = 0; md = 0;
  endtask

  task automatic model_step();
    bit d;
    d = 0;
    case (ms)
      0: if (run_req) ms = 1;
      1: if (mp == 4 && opcode == 0) ms = 2;
         else if (mp == 7) begin
           mp = 0; mi = (mi + 1) % 4; d = 1;
           if (step_en) ms = 3;
         end else mp++;
      2: if (run_req) begin ms = 1; mp = 5; end
      default: if (step_req || run_req) begin ms = 1; mp = 0; end
    endcase
    md = d;
  endtask

  task automatic compare_model();
    chk("phase", phase, mp);
    chk("run_st", run_st, ms);
    chk("strobes", strb, exp_strb(ms, mp, opcode, zero));
    chk("instr_done", instr_done, md);
    chk("icnt", icnt, mi);
  endtask

  task automatic drive(bit rr, bit se, bit sr, logic [2:0] op, bit z);
    run_req = rr; step_en = se; step_req = sr; opcode = op; zero = z;
    @(negedge clk);
    obs = strb;
  endtask

  task automatic finish_cycle();
    compare_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(bit rr, bit se, bit sr, logic [2:0] op, bit z);
    drive(rr, se, sr, op, z);
    finish_cycle();
  endtask

  task automatic run_instr(logic [2:0] op, bit z, bit se,
                           output logic [7:0] incm, ldpcm, dem, wrm);
    for (int p = 0; p < 8; p++) begin
      tick(0, se, 0, op, z);
      incm[p] = obs[5]; ldpcm[p] = obs[4]; dem[p] = obs[3]; wrm[p] = obs[1];
    end
  endtask

  initial begin
    logic [7:0] im, lm, dm, wm;
    int cnt;
    tbl[0] = '{1'b1, 3'd0, 2'd0, 9'b000000000};
    tbl[1] = '{1'b0, 3'd0, 2'd1, 9'b100000000};
    tbl[2] = '{1'b0, 3'd1, 2'd1, 9'b110000000};
    tbl[3] = '{1'b0, 3'd2, 2'd1, 9'b111000000};
    tbl[4] = '{1'b0, 3'd3, 2'd1, 9'b111000000};
    tbl[5] = '{1'b0, 3'd4, 2'd1, 9'b000100000};
    tbl[6] = '{1'b0, 3'd5, 2'd1, 9'b010000000};
    tbl[7] = '{1'b0, 3'd6, 2'd1, 9'b010000000};
    tbl[8] = '{1'b0, 3'd7, 2'd1, 9'b010000100};
    rstn = 1'b0; run_req = 0; step_en = 0; step_req = 0; opcode = 3'd2; zero = 0;
    model_reset();
    #2;
    compare_model();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    // stays stopped without run_req
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 3'd2, 0);
    chk("stopped_st", run_st, 0);
    chk("stopped_ph", phase, 0);
    // one ADD instruction from a run_req pulse
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rr, 0, 0, 3'd2, 0);
      chk($sformatf("tbl%0d_ph", i), phase, tbl[i].ph);
      chk($sformatf("tbl%0d_st", i), run_st, tbl[i].st);
      chk($sformatf("tbl%0d_strb", i), obs, tbl[i].s);
      finish_cycle();
    end
    chk("add_done", instr_done, 1);
    chk("add_icnt", icnt, 1);
    chk("add_ph0", phase, 0);
    run_instr(3'd1, 1, 0, im, lm, dm, wm);
    chk("skz_z1_inc", im, 8'h50);
    run_instr(3'd1, 0, 0, im, lm, dm, wm);
    chk("skz_z0_inc", im, 8'h10);
    chk("icnt_3", icnt, 3);
    run_instr(3'd7, 0, 0, im, lm, dm, wm);
    chk("jmp_ldpc", lm, 8'hc0);
    chk("jmp_inc", im, 8'h90);
    chk("icnt_wrap", icnt, 0);
    run_instr(3'd6, 0, 0, im, lm, dm, wm);
    chk("sto_wr", wm, 8'h80);
    chk("sto_de", dm, 8'hc0);
    // HLT freezes at phase 4, resumes at 5
    for (int p = 0; p < 5; p++) tick(0, 0, 0, 3'd0, 0);
    chk("hlt_st", run_st, 2);
    chk("hlt_ph", phase, 4);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 3'd0, 0);
      if (obs == 9'b1) cnt++;
    end
    chk("hlt_hold", cnt, 10);
    tick(1, 0, 0, 3'd0, 0);
    chk("hlt_resume_ph", phase, 5);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 3'd0, 0);
      cnt += obs[5];
    end
    chk("hlt_no_inc", cnt, 0);
    chk("hlt_done", instr_done, 1);
    chk("hlt_icnt", icnt, 2);
    // single-step
    run_instr(3'd2, 0, 1, im, lm, dm, wm);
    chk("pause_st", run_st, 3);
    chk("pause_icnt", icnt, 3);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 0, 3'd2, 0);
      if (obs == 9'b0) cnt++;
    end
    chk("pause_quiet", cnt, 6);
    tick(0, 1, 1, 3'd2, 0);
    run_instr(3'd2, 0, 1, im, lm, dm, wm);
    chk("step_back_paused", run_st, 3);
    chk("step_icnt", icnt, 0);
    tick(0, 0, 0, 3'd2, 0);
    tick(0, 0, 0, 3'd2, 0);
    chk("no_auto_resume", run_st, 3);
    tick(1, 0, 0, 3'd2, 0);
    chk("run_resume", run_st, 1);
    // async reset mid-instruction
    for (int p = 0; p < 5; p++) tick(0, 0, 0, 3'd2, 0);
    chk("pre_rst_ph", phase, 5);
    rstn = 1'b0;
    #1;
    chk("arst_ph", phase, 0);
    chk("arst_icnt", icnt, 0);
    chk("arst_st", run_st, 0);
    chk("arst_strb", strb, 0);
    model_reset();
    #1 rstn = 1'b1;
    run_req = 0;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rstn = 1'b0;
        #1;
        model_reset();
        compare_model();
        #1 rstn = 1'b1;
      end
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
